seq_stream_gen: RTL
===================

// Module: seq_stream_gen
// PURPOSE
//  Serial stimulus transmitter for the sequence-detector blocks: it drives the one-bit
//  input stream j that a Moore/Mealy detector consumes and counts the detector's output w.
//  A word of up to MAX_LEN bits is sent MSB-first, repeated a programmable number of times
//  with optional idle gaps. Used for self-checking detector benches and on-board stream replay.
// PARAMETERS
//  MAX_LEN    16  max pattern length in bits
//  LEN_W      5   width of len_in; must hold MAX_LEN
//  REP_W      4   width of reps_in
//  GAP_LEN    0   idle cycles inserted between repetitions (0 = back-to-back)
//  IDLE_LEVEL 0   level driven on j when no pattern bit is being sent
//  CNT_W      8   width of hit_count
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  start      in   1        request to transmit; sampled only in IDLE
//  word_in    in   MAX_LEN  pattern; bit len_in-1 is sent first
//  len_in     in   LEN_W    pattern length, valid range 1..MAX_LEN
//  reps_in    in   REP_W    repetition count; 0 is treated as 1
//  w_in       in   1        detector output fed back for counting
//  j          out  1        serial stream to the detector (registered)
//  bit_valid  out  1        high while j carries a pattern bit
//  busy       out  1        high from an accepted start until the last bit has been sent
//  done       out  1        one-cycle pulse after the final bit
//  err        out  1        one-cycle pulse when start is rejected for a bad length
//  hit_count  out  CNT_W    number of w_in=1 cycles in the current run
// BEHAVIOUR
//  Reset (sync, rst=1 at an edge): state=IDLE, j=IDLE_LEVEL, bit_valid=0, busy=0, done=0,
//   err=0, hit_count=0. Reset mid-run aborts the run immediately; done is not pulsed.
//  States: IDLE, SEND, GAP, DONE. All outputs are registered.
//  IDLE: at an edge with start=1:
//   - If 1<=len_in<=MAX_LEN: capture word, len, and reps (0 becomes 1); clear hit_count;
//     go to SEND. At that same edge j=word[len-1], bit_valid=1, busy=1. Latency is 0
//     cycles after the accepting edge.
//   - Otherwise: stay in IDLE and pulse err for one cycle.
//  SEND: each edge advances to the next lower bit. After bit 0 of a repetition:
//   - If repetitions remain and GAP_LEN>0, go to GAP.
//   - If repetitions remain and GAP_LEN=0, the next edge sends bit len-1 again (no bubble).
//   - If this was the last repetition, go to DONE.
//  GAP: exactly GAP_LEN cycles; j=IDLE_LEVEL, bit_valid=0, busy stays 1. Then SEND from bit len-1.
//  DONE: one cycle; done=1, busy=0, bit_valid=0, j=IDLE_LEVEL. Then IDLE.
//  start outside IDLE (including the DONE cycle) is ignored; no err, and captured values
//   do not change.
//  hit_count increments at each edge where w_in=1 and state is SEND, GAP or DONE. DONE is
//   counted to cover the one-cycle Moore lag. The count saturates at 2^CNT_W-1 and holds
//   its value in IDLE until the next accepted start.
//  Total run length from the accepting edge to the done edge: len*reps + GAP_LEN*(reps-1) cycles.
// TESTING
//  1) word=4'b1100, len=4, reps=1, GAP_LEN=0: start at edge T0 -> j=1,1,0,0 at T0..T3;
//     done=1 at T4; busy=0 from T4.
//  2) word=3'b101, len=3, reps=3, GAP_LEN=2 -> j=1,0,1,0,0,1,0,1,0,0,1,0,1; bit_valid=0
//     only in the 4 gap cycles; done after 13 cycles.
//  3) len_in=0, and len_in=MAX_LEN+1 -> err pulses once, busy stays 0, j stays IDLE_LEVEL.
//  4) start pulsed again during busy with a different word -> ignored; the original stream
//     completes unchanged.
//  5) Loopback to a 1101 Moore detector, word=7'b1101101, len=7 -> hit_count=2 at done;
//     the same run with the Mealy detector -> also 2; XOR of the two w lines is 1 only in
//     the lag cycles.
//  6) rst=1 during the 3rd bit of a run -> next cycle j=IDLE_LEVEL, busy=0, hit_count=0,
//     no done pulse; a new start is accepted immediately after.

Source files
------------

// File: rtl/seq_stream_gen_if.sv
// Handshake/bus bundle between a stream-generator client and seq_stream_gen.
// The client (master) programs the pattern and feeds the detector's w back in;
// the generator (slave) drives the serial stream and status.
interface seq_stream_gen_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int REP_W   = 4,
  parameter int CNT_W   = 8
);
  logic               start;
  logic [MAX_LEN-1:0] word_in;
  logic [LEN_W-1:0]   len_in;
  logic [REP_W-1:0]   reps_in;
  logic               w_in;
  logic               j;
  logic               bit_valid;
  logic               busy;
  logic               done;
  logic               err;
  logic [CNT_W-1:0]   hit_count;

  modport master (
    output start, word_in, len_in, reps_in, w_in,
    input  j, bit_valid, busy, done, err, hit_count
  );

  modport slave (
    input  start, word_in, len_in, reps_in, w_in,
    output j, bit_valid, busy, done, err, hit_count
  );
endinterface

// File: rtl/seq_stream_gen.sv
// Serial stimulus transmitter for sequence detectors. Sends a word MSB-first
// (bit len-1 first), repeated reps times with optional idle gaps, and counts
// the detector's w output over the run. All outputs are registered; the first
// pattern bit appears on j at the same edge that accepts start.
module seq_stream_gen #(
  parameter int   MAX_LEN    = 16,
  parameter int   LEN_W      = 5,
  parameter int   REP_W      = 4,
  parameter int   GAP_LEN    = 0,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   CNT_W      = 8
) (
  input  logic           clk,
  input  logic           rst,
  seq_stream_gen_if.slave bus
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  // Gap counter load value: counts GAP_LEN-1 down to 0, one idle cycle each.
  localparam logic [GAP_W-1:0] GAP_LAST  = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  // Pattern captured at the accepting edge; top is the index of the first bit sent.
  typedef struct packed {
    logic [MAX_LEN-1:0] word;
    logic [IDX_W-1:0]   top;
  } cfg_t;

  state_t           state;
  cfg_t             cfg_q;
  logic [IDX_W-1:0] bit_idx;   // index of the bit currently on j
  logic [REP_W-1:0] rep_left;  // repetitions remaining, including the current one
  logic [GAP_W-1:0] gap_cnt;
  logic             j_q;
  logic             bv_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] hit_q;

  logic             len_ok;
  logic             accept;
  logic [IDX_W-1:0] start_top;
  logic [REP_W-1:0] reps_eff;

  assign len_ok    = (bus.len_in != '0) && (bus.len_in <= MAX_LEN_V);
  assign accept    = (state == S_IDLE) && bus.start && len_ok;
  assign start_top = IDX_W'(bus.len_in - LEN_ONE);
  assign reps_eff  = (bus.reps_in == '0) ? REP_ONE : bus.reps_in;

  // Main sequencer: walks bits, repetitions and gaps; drives registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cfg_q    <= '0;
      bit_idx  <= '0;
      rep_left <= '0;
      gap_cnt  <= '0;
      j_q      <= IDLE_LEVEL;
      bv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (len_ok) begin
              cfg_q.word <= bus.word_in;
              cfg_q.top  <= start_top;
              bit_idx    <= start_top;
              rep_left   <= reps_eff;
              j_q        <= bus.word_in[start_top];
              bv_q       <= 1'b1;
              busy_q     <= 1'b1;
              state      <= S_SEND;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - IDX_ONE;
            j_q     <= cfg_q.word[bit_idx - IDX_ONE];
          end else if (rep_left != REP_ONE) begin
            rep_left <= rep_left - REP_ONE;
            if (GAP_LEN > 0) begin
              gap_cnt <= GAP_LAST;
              j_q     <= IDLE_LEVEL;
              bv_q    <= 1'b0;
              state   <= S_GAP;
            end else begin
              // Back-to-back: restart the word with no bubble.
              bit_idx <= cfg_q.top;
              j_q     <= cfg_q.word[cfg_q.top];
            end
          end else begin
            j_q    <= IDLE_LEVEL;
            bv_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            bit_idx <= cfg_q.top;
            j_q     <= cfg_q.word[cfg_q.top];
            bv_q    <= 1'b1;
            state   <= S_SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: begin
          // DONE lasts one cycle; start is deliberately not looked at here.
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Hit counter: cleared on accept, counts w_in outside IDLE (DONE covers the
  // Moore detector's one-cycle lag), saturates, and holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= '0;
    end else if (accept) begin
      hit_q <= '0;
    end else if ((state != S_IDLE) && bus.w_in && (hit_q != CNT_MAX)) begin
      hit_q <= hit_q + CNT_ONE;
    end
  end

  assign bus.j         = j_q;
  assign bus.bit_valid = bv_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.hit_count = hit_q;

endmodule
